// File: rtl/lsu.sv
// lsu -- load/store unit sitting after the execute ALU.
//
// Takes one memory uop at a time from execute and runs a single
// request/grant/response transaction on the data-memory port. It then
// presents the extended load result, or the store completion, to writeback.
// Only one transaction is ever in flight.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   ex_*                uop from execute (valid/ready; sampled on accept only)
//   mem_*               data-memory req/gnt + rvalid/rdata port
//   wb_*                result to writeback (valid/ready)
module lsu #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   ex_addr_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic              ex_store_i,
  input  logic [1:0]        ex_size_i,
  input  logic              ex_unsigned_i,
  input  logic [4:0]        ex_rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_rdata_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_we_o,
  output logic              wb_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;     // already lane-replicated
  logic [XLEN/8-1:0] wstrb_q, wstrb_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              accept;
  logic              mis_in;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN/8-1:0] lane_wstrb;
  logic [XLEN-1:0]   rshift;
  logic [XLEN-1:0]   load_ext;

  assign ex_ready_o = (state_q == IDLE) & ~rst_i;
  assign accept     = ex_valid_i & ex_ready_o;

  assign mis_in = (ex_size_i == 2'd3) |
                  ((ex_size_i == 2'd1) & ex_addr_i[0]) |
                  ((ex_size_i == 2'd2) & (ex_addr_i[1:0] != 2'b00));

  // Store lanes: replicate the right-aligned datum across the word so the
  // strobes alone pick the target bytes.
  always_comb begin
    lane_wdata = ex_wdata_i;
    lane_wstrb = '1;
    case (ex_size_i)
      2'd0: begin
        lane_wdata = {4{ex_wdata_i[7:0]}};
        lane_wstrb = 4'b0001 << ex_addr_i[1:0];
      end
      2'd1: begin
        lane_wdata = {2{ex_wdata_i[15:0]}};
        lane_wstrb = 4'b0011 << ex_addr_i[1:0];
      end
      default: ;
    endcase
  end

  // Load extraction: bring the addressed byte/half down to bit 0, then extend.
  assign rshift = mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rshift;
    case (size_q)
      2'd0: load_ext = uns_q ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                             : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      2'd1: load_ext = uns_q ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                             : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = ex_addr_i;
        wdata_d = lane_wdata;
        wstrb_d = (ex_store_i & ~mis_in) ? lane_wstrb : '0;
        store_d = ex_store_i;
        size_d  = ex_size_i;
        uns_d   = ex_unsigned_i;
        rd_d    = ex_rd_i;
        mis_d   = mis_in;
        rdata_d = '0;
        // Faulting accesses never touch the bus.
        state_d = mis_in ? RESP : REQ;
      end
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i) begin
        // For stores rvalid is only the write ack; rdata is dropped.
        rdata_d = store_q ? '0 : load_ext;
        state_d = RESP;
      end
      RESP: if (wb_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      store_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_we_o      = store_q;
  assign mem_addr_o    = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata_o   = wdata_q;
  assign mem_wstrb_o   = wstrb_q;

  assign wb_valid_o    = (state_q == RESP);
  assign wb_rdata_o    = rdata_q;
  assign wb_rd_o       = rd_q;
  assign wb_misalign_o = mis_q;
  assign wb_we_o       = ~store_q & ~mis_q & (rd_q != 5'd0);

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_addr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        ex_store_i = 1'b0;
  logic [1:0]  ex_size_i = '0;
  logic        ex_unsigned_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [31:0] wb_rdata_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o, wb_misalign_o;

  int errs = 0;
  int checks = 0;

  lsu #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_addr_i(ex_addr_i),
    .ex_wdata_i(ex_wdata_i), .ex_store_i(ex_store_i), .ex_size_i(ex_size_i),
    .ex_unsigned_i(ex_unsigned_i), .ex_rd_i(ex_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rdata_o(wb_rdata_o),
    .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_misalign_o(wb_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Snapshot of what one zero-stall transaction looked like, cycle by cycle.
  typedef struct {
    logic        rdy0;
    logic        req1, we1, rdy1;
    logic [31:0] addr1, wdata1;
    logic [3:0]  wstrb1;
    logic        req2, vld2;
    logic        vld3, we3, mis3;
    logic [31:0] rdata3;
    logic [4:0]  rd3;
    logic        vld4, rdy4;
  } obs_t;

  // Drives one uop with grant on the first REQ cycle, rvalid one cycle later
  // and an immediately ready writeback. Starts and ends on a falling edge
  // with the DUT idle.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic st,
                      input logic [1:0] sz, input logic un, input logic [4:0] rd,
                      input logic [31:0] rdata, output obs_t o);
    o.rdy0 = ex_ready_o;
    ex_valid_i = 1'b1; ex_addr_i = a; ex_wdata_i = wd; ex_store_i = st;
    ex_size_i = sz; ex_unsigned_i = un; ex_rd_i = rd;
    @(negedge clk_i);
    ex_valid_i = 1'b0; ex_addr_i = 32'hFFFF_FFFF; ex_wdata_i = '0; ex_rd_i = 5'd31;
    o.req1 = mem_req_o; o.we1 = mem_we_o; o.rdy1 = ex_ready_o;
    o.addr1 = mem_addr_o; o.wdata1 = mem_wdata_o; o.wstrb1 = mem_wstrb_o;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    o.req2 = mem_req_o; o.vld2 = wb_valid_o;
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5555_5555;
    o.vld3 = wb_valid_o; o.we3 = wb_we_o; o.mis3 = wb_misalign_o;
    o.rdata3 = wb_rdata_o; o.rd3 = wb_rd_o;
    wb_ready_i = 1'b1;
    @(negedge clk_i);
    wb_ready_i = 1'b0;
    o.vld4 = wb_valid_o; o.rdy4 = ex_ready_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready got %b exp 0", ex_ready_o); end
    checks++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rst_req got %b exp 0", mem_req_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errs++; $display("FAIL rst_wbvalid got %b exp 0", wb_valid_o); end
    checks++; if ({mem_addr_o, mem_wstrb_o, wb_rdata_o} !== '0) begin errs++; $display("FAIL rst_regs got %h/%h/%h exp 0", mem_addr_o, mem_wstrb_o, wb_rdata_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1) begin errs++; $display("FAIL rst_release_ready got %b exp 1", ex_ready_o); end
  endtask

  task automatic test_word_load();
    obs_t o;
    xact(32'h8000_0004, 32'h0, 1'b0, 2'd2, 1'b0, 5'd10, 32'hDEAD_BEEF, o);
    checks++; if (o.rdy0 !== 1'b1) begin errs++; $display("FAIL wl_ready got %b exp 1", o.rdy0); end
    checks++; if ({o.req1, o.we1, o.rdy1} !== 3'b100) begin errs++; $display("FAIL wl_req got %b exp 100", {o.req1, o.we1, o.rdy1}); end
    checks++; if (o.addr1 !== 32'h8000_0004) begin errs++; $display("FAIL wl_addr got %h exp 80000004", o.addr1); end
    checks++; if (o.wstrb1 !== 4'b0000) begin errs++; $display("FAIL wl_wstrb got %b exp 0000", o.wstrb1); end
    checks++; if ({o.req2, o.vld2} !== 2'b00) begin errs++; $display("FAIL wl_wait got %b exp 00", {o.req2, o.vld2}); end
    checks++; if (o.vld3 !== 1'b1) begin errs++; $display("FAIL wl_latency got %b exp 1", o.vld3); end
    checks++; if (o.rdata3 !== 32'hDEAD_BEEF) begin errs++; $display("FAIL wl_rdata got %h exp deadbeef", o.rdata3); end
    checks++; if ({o.we3, o.mis3, o.rd3} !== {1'b1, 1'b0, 5'd10}) begin errs++; $display("FAIL wl_flags got %b/%b/%0d exp 1/0/10", o.we3, o.mis3, o.rd3); end
    checks++; if ({o.vld4, o.rdy4} !== 2'b01) begin errs++; $display("FAIL wl_done got %b exp 01", {o.vld4, o.rdy4}); end
  endtask

  task automatic test_byte_half_load();
    obs_t o;
    xact(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b0, 5'd1, 32'h8012_3456, o);
    checks++; if (o.rdata3 !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb got %h exp ffffff80", o.rdata3); end
    xact(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b1, 5'd1, 32'h8012_3456, o);
    checks++; if (o.rdata3 !== 32'h0000_0080) begin errs++; $display("FAIL lbu got %h exp 00000080", o.rdata3); end
    xact(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 5'd2, 32'h8001_1234, o);
    checks++; if (o.rdata3 !== 32'hFFFF_8001) begin errs++; $display("FAIL lh got %h exp ffff8001", o.rdata3); end
    checks++; if (o.addr1 !== 32'h8000_0000) begin errs++; $display("FAIL lh_addr got %h exp 80000000", o.addr1); end
    xact(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b1, 5'd2, 32'h8001_1234, o);
    checks++; if (o.rdata3 !== 32'h0000_8001) begin errs++; $display("FAIL lhu got %h exp 00008001", o.rdata3); end
    xact(32'h8000_0001, 32'h0, 1'b0, 2'd0, 1'b0, 5'd4, 32'hAA11_7FBB, o);
    checks++; if (o.rdata3 !== 32'h0000_007F) begin errs++; $display("FAIL lb_pos got %h exp 0000007f", o.rdata3); end
  endtask

  task automatic test_store();
    obs_t o;
    xact(32'h8000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 5'd9, 32'hFFFF_FFFF, o);
    checks++; if ({o.req1, o.we1} !== 2'b11) begin errs++; $display("FAIL sh_req got %b exp 11", {o.req1, o.we1}); end
    checks++; if (o.wdata1 !== 32'hABCD_ABCD) begin errs++; $display("FAIL sh_wdata got %h exp abcdabcd", o.wdata1); end
    checks++; if (o.wstrb1 !== 4'b1100) begin errs++; $display("FAIL sh_wstrb got %b exp 1100", o.wstrb1); end
    checks++; if (o.addr1 !== 32'h8000_0000) begin errs++; $display("FAIL sh_addr got %h exp 80000000", o.addr1); end
    checks++; if ({o.vld3, o.we3, o.rdata3} !== {1'b1, 1'b0, 32'h0}) begin errs++; $display("FAIL sh_wb got %b/%b/%h exp 1/0/0", o.vld3, o.we3, o.rdata3); end
    xact(32'h8000_0001, 32'hFFFF_FFA5, 1'b1, 2'd0, 1'b0, 5'd9, 32'h0, o);
    checks++; if ({o.wdata1, o.wstrb1} !== {32'hA5A5_A5A5, 4'b0010}) begin errs++; $display("FAIL sb_lane got %h/%b exp a5a5a5a5/0010", o.wdata1, o.wstrb1); end
    xact(32'h8000_0010, 32'h0BAD_F00D, 1'b1, 2'd2, 1'b0, 5'd9, 32'h0, o);
    checks++; if ({o.wdata1, o.wstrb1} !== {32'h0BAD_F00D, 4'b1111}) begin errs++; $display("FAIL sw_lane got %h/%b exp 0badf00d/1111", o.wdata1, o.wstrb1); end
  endtask

  task automatic test_grant_stall();
    logic [31:0] w0;
    logic        to;
    ex_valid_i = 1'b1; ex_addr_i = 32'h8000_0006; ex_wdata_i = 32'h1111_2222;
    ex_store_i = 1'b0; ex_size_i = 2'd1; ex_unsigned_i = 1'b0; ex_rd_i = 5'd7;
    @(negedge clk_i);
    // Scramble the execute inputs: only the accept-cycle values may matter.
    ex_valid_i = 1'b0; ex_addr_i = 32'hFFFF_FFFF; ex_size_i = 2'd2; ex_rd_i = 5'd0; ex_store_i = 1'b1;
    w0 = mem_wdata_o;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req_o, ex_ready_o, mem_we_o} !== 3'b100) begin errs++; $display("FAIL gs_req%0d got %b exp 100", i, {mem_req_o, ex_ready_o, mem_we_o}); end
      checks++; if ({mem_addr_o, mem_wstrb_o, mem_wdata_o} !== {32'h8000_0004, 4'b0000, w0}) begin errs++; $display("FAIL gs_bus%0d got %h/%b/%h exp 80000004/0000/%h", i, mem_addr_o, mem_wstrb_o, mem_wdata_o, w0); end
      mem_gnt_i = (i == 3);
      mem_rvalid_i = (i < 3);           // stray responses while in REQ
      mem_rdata_i = 32'h0123_4567;
      @(negedge clk_i);
    end
    mem_gnt_i = 1'b0;
    checks++; if ({mem_req_o, wb_valid_o} !== 2'b00) begin errs++; $display("FAIL gs_wait got %b exp 00", {mem_req_o, wb_valid_o}); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEDC_0000;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    to = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({wb_valid_o, wb_we_o, wb_misalign_o, wb_rd_o, wb_rdata_o} !== {3'b110, 5'd7, 32'hFFFF_FEDC}) begin
        errs++; $display("FAIL gs_wb%0d got %b%b%b/%0d/%h exp 110/7/fffffedc", i, wb_valid_o, wb_we_o, wb_misalign_o, wb_rd_o, wb_rdata_o);
      end
      wb_ready_i = (i == 2);
      @(negedge clk_i);
    end
    wb_ready_i = 1'b0;
    checks++; if ({wb_valid_o, ex_ready_o} !== 2'b01) begin errs++; $display("FAIL gs_done got %b exp 01", {wb_valid_o, ex_ready_o}); end
  endtask

  task automatic test_misalign();
    logic [31:0] va [4] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0000, 32'h8000_0002};
    logic [1:0]  vs [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic        vst[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      ex_valid_i = 1'b1; ex_addr_i = va[i]; ex_size_i = vs[i]; ex_store_i = vst[i];
      ex_rd_i = 5'd3; ex_wdata_i = 32'hCAFE_CAFE; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      ex_valid_i = 1'b0;
      checks++; if ({mem_req_o, wb_valid_o, wb_misalign_o, wb_we_o} !== 4'b0110) begin
        errs++; $display("FAIL mis%0d got req/vld/mis/we=%b exp 0110", i, {mem_req_o, wb_valid_o, wb_misalign_o, wb_we_o});
      end
      checks++; if (wb_rdata_o !== 32'h0) begin errs++; $display("FAIL mis%0d_rdata got %h exp 0", i, wb_rdata_o); end
      wb_ready_i = 1'b1;
      @(negedge clk_i);
      wb_ready_i = 1'b0; mem_gnt_i = 1'b0;
      checks++; if ({mem_req_o, wb_valid_o, ex_ready_o} !== 3'b001) begin errs++; $display("FAIL mis%0d_done got %b exp 001", i, {mem_req_o, wb_valid_o, ex_ready_o}); end
    end
    xact(32'h8000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 5'd0, 32'h1234_5678, o);
    checks++; if ({o.vld3, o.we3, o.rdata3} !== {2'b10, 32'h1234_5678}) begin errs++; $display("FAIL rd0 got %b/%b/%h exp 1/0/12345678", o.vld3, o.we3, o.rdata3); end
  endtask

  task automatic test_reset_mid();
    ex_valid_i = 1'b1; ex_addr_i = 32'h8000_0008; ex_store_i = 1'b0;
    ex_size_i = 2'd2; ex_rd_i = 5'd5;
    @(negedge clk_i);
    ex_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if ({mem_req_o, ex_ready_o, wb_valid_o} !== 3'b000) begin errs++; $display("FAIL rm_inrst got %b exp 000", {mem_req_o, ex_ready_o, wb_valid_o}); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1) begin errs++; $display("FAIL rm_ready got %b exp 1", ex_ready_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({wb_valid_o, ex_ready_o, mem_req_o} !== 3'b010) begin errs++; $display("FAIL rm_stray%0d got %b exp 010", i, {wb_valid_o, ex_ready_o, mem_req_o}); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_back_to_back();
    obs_t a, b;
    xact(32'h8000_0020, 32'h0, 1'b0, 2'd2, 1'b0, 5'd11, 32'h0000_0001, a);
    xact(32'h8000_0024, 32'h0, 1'b0, 2'd0, 1'b1, 5'd12, 32'h0000_00FF, b);
    checks++; if ({a.rdata3, a.rd3} !== {32'h1, 5'd11}) begin errs++; $display("FAIL b2b_a got %h/%0d exp 1/11", a.rdata3, a.rd3); end
    checks++; if ({b.rdy0, b.rdata3, b.rd3} !== {1'b1, 32'hFF, 5'd12}) begin errs++; $display("FAIL b2b_b got %b/%h/%0d exp 1/ff/12", b.rdy0, b.rdata3, b.rd3); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_half_load();
    test_store();
    test_grant_stall();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit downstream of the execute ALU.
- Accepts one memory uop per transaction from the execute stage. The address is the ALU adder result for LOAD/STORE, and the store data is rs2.
- Runs a single outstanding request/grant/response transaction on the data-memory port.
- Hands the aligned, extended load result (or store completion) to writeback via a valid/ready handshake.
- Blocking: non-pipelined, one transaction in flight.

Parameters:
- XLEN, 32, datapath and address width. Only 32 is supported; the strobe width is XLEN/8.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  synchronous, active-high reset
- ex_valid_i  in  1  execute stage presents a memory uop
- ex_ready_o  out  1  LSU can accept a uop
- ex_addr_i  in  XLEN  byte address (ALU adder result)
- ex_wdata_i  in  XLEN  store data (rs2), right-aligned
- ex_store_i  in  1  1 = store, 0 = load
- ex_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- ex_unsigned_i  in  1  load zero-extends (LBU/LHU)
- ex_rd_i  in  5  load destination register
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write request
- mem_addr_o  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_wstrb_o  out  XLEN/8  byte write strobes (0 for loads)
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid (read data or write ack)
- mem_rdata_i  in  XLEN  read word
- wb_valid_o  out  1  result available to writeback
- wb_ready_i  in  1  writeback accepts the result
- wb_rdata_o  out  XLEN  extended load data (0 for stores)
- wb_rd_o  out  5  destination register
- wb_we_o  out  1  register-file write enable
- wb_misalign_o  out  1  misaligned or illegal-size access

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: all registered outputs are 0. ex_ready_o = (state==IDLE) & ~rst_i.
- IDLE
  - ex_ready_o = 1.
  - On ex_valid_i & ex_ready_o, capture addr, wdata, store, size, unsigned and rd.
  - Misaligned or illegal access goes to RESP with misalign = 1 and no bus activity.
    - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - Any other access goes to REQ.
- REQ
  - mem_req_o = 1. mem_we_o, mem_addr_o, mem_wdata_o and mem_wstrb_o stay stable until mem_gnt_i.
  - On mem_gnt_i, go to WAIT.
- WAIT
  - mem_req_o = 0.
  - On mem_rvalid_i, register the processed result and go to RESP.
  - Stores also wait for rvalid, which acts as the write ack; rdata is ignored.
- RESP
  - wb_valid_o = 1 and all wb_* outputs are held stable until wb_ready_i.
  - On wb_ready_i, go to IDLE. The next uop can be accepted the cycle after.
- Minimum latency: accept at cycle T, mem_req_o at T+1 with gnt, rvalid at T+2, wb_valid_o at T+3.
- Misaligned latency: wb_valid_o at T+1.
- Store data lanes:
  - byte: wdata = {4{b}}, wstrb = 4'b0001 << addr[1:0].
  - half: wdata = {2{h}}, wstrb = 4'b0011 << addr[1:0].
  - word: wdata = wdata, wstrb = 4'b1111.
- Load extraction:
  - Shift rdata right by 8*addr[1:0], then take the byte or half.
  - Sign-extend from bit 7/15 unless ex_unsigned_i; words pass through unchanged.
- Writeback flags:
  - wb_we_o = ~store & ~misalign & (rd != 0).
  - wb_rdata_o = 0 for stores and for misaligned accesses.
- mem_rvalid_i outside WAIT and mem_gnt_i outside REQ are ignored.
- Reset mid-transaction: the FSM goes to IDLE at the next edge and mem_req_o drops. A late response after reset is ignored.
- ex_* inputs are sampled only on the accept cycle and may change afterwards.

Test Plan:
1. Word load: addr=0x8000_0004, gnt in the same cycle as req, rvalid one cycle later with rdata=0xDEAD_BEEF. Required: mem_addr_o=0x8000_0004, wstrb=0, wb_rdata_o=0xDEAD_BEEF, wb_we_o=1, wb_valid_o at T+3.
2. Signed and unsigned byte load: addr=0x8000_0003, rdata=0x80xx_xxxx. Required: LB gives 0xFFFF_FF80; LBU gives 0x0000_0080. Half load at addr 0x8000_0002 with rdata 0x8001_xxxx: LH gives 0xFFFF_8001.
3. Store half: addr=0x8000_0002, wdata=0x1234_ABCD. Required: mem_we_o=1, mem_wdata_o=0xABCD_ABCD, mem_wstrb_o=4'b1100, mem_addr_o=0x8000_0000, wb_we_o=0 after the ack.
4. Grant stall: gnt held low for 3 cycles. Required: mem_req_o and addr/wdata/wstrb stay stable for all 4 REQ cycles and ex_ready_o=0 throughout. With wb_ready_i low for 2 cycles, wb_* outputs stay stable.
5. Misaligned word at addr 0x8000_0001. Required: no mem_req_o ever, wb_valid_o at T+1 with wb_misalign_o=1, wb_we_o=0. Also a load with rd=0 gives wb_we_o=0.
6. rst_i asserted while in WAIT. Required: mem_req_o=0 and ex_ready_o=0 during reset, then 1 after; a stray rvalid after reset produces no wb_valid_o.
